// File: rtl/multiplication.sv
// multiplication
// Sequential shift-and-add unsigned multiplier with independent valid/ready
// handshakes on each operand and on the double-width product. One multiplier
// bit is consumed per clock, so a product appears exactly SIZE cycles after the
// last operand is captured, regardless of operand values.
//
// Ports:
//   clk                        clock, rising-edge active
//   rst                        asynchronous active-high reset
//   input_multiplicand_tdata   multiplicand operand (SIZE bits)
//   input_multiplicand_tvalid  multiplicand valid
//   input_multiplicand_tready  multiplicand accept (IDLE and not yet captured)
//   input_multiplier_tdata     multiplier operand (SIZE bits)
//   input_multiplier_tvalid    multiplier valid
//   input_multiplier_tready    multiplier accept (IDLE and not yet captured)
//   output_tdata               registered unsigned product (2*SIZE bits)
//   output_tvalid              product valid
//   output_tready              downstream accept
module multiplication #(
  parameter int SIZE = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SIZE-1:0]   input_multiplicand_tdata,
  input  logic              input_multiplicand_tvalid,
  output logic              input_multiplicand_tready,
  input  logic [SIZE-1:0]   input_multiplier_tdata,
  input  logic              input_multiplier_tvalid,
  output logic              input_multiplier_tready,
  output logic [2*SIZE-1:0] output_tdata,
  output logic              output_tvalid,
  input  logic              output_tready
);

  localparam int CW = $clog2(SIZE + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(SIZE - 1);
  localparam logic [2*SIZE-1:0] P_ZERO   = {(2*SIZE){1'b0}};
  localparam logic [SIZE-1:0]   OP_ZERO  = {SIZE{1'b0}};

  logic [1:0]        state_r;
  logic              have_mcand_r;
  logic              have_mplier_r;
  logic [SIZE-1:0]   mcand_r;
  logic [SIZE-1:0]   mplier_r;
  logic [2*SIZE-1:0] acc_r;
  logic [2*SIZE-1:0] a_r;
  logic [SIZE-1:0]   b_r;
  logic [CW-1:0]     cnt_r;
  logic [2*SIZE-1:0] output_tdata_r;
  logic              output_tvalid_r;

  logic              mcand_fire_s;
  logic              mplier_fire_s;
  logic [SIZE-1:0]   mcand_next_s;
  logic [SIZE-1:0]   mplier_next_s;
  logic              start_s;
  logic [2*SIZE-1:0] addend_s;
  logic [2*SIZE-1:0] sum_s;

  // Input readiness comes straight from registered state and capture flags.
  assign input_multiplicand_tready = (state_r == ST_IDLE) & ~have_mcand_r;
  assign input_multiplier_tready   = (state_r == ST_IDLE) & ~have_mplier_r;

  assign output_tdata  = output_tdata_r;
  assign output_tvalid = output_tvalid_r;

  // Handshake decode, operand bypass for same-edge start, and partial-product add.
  always_comb begin
    mcand_fire_s  = input_multiplicand_tvalid & input_multiplicand_tready;
    mplier_fire_s = input_multiplier_tvalid & input_multiplier_tready;

    // An operand arriving on the start edge is not yet in its register.
    if (mcand_fire_s) begin
      mcand_next_s = input_multiplicand_tdata;
    end else begin
      mcand_next_s = mcand_r;
    end

    if (mplier_fire_s) begin
      mplier_next_s = input_multiplier_tdata;
    end else begin
      mplier_next_s = mplier_r;
    end

    start_s = (state_r == ST_IDLE)
            & (have_mcand_r  | mcand_fire_s)
            & (have_mplier_r | mplier_fire_s);

    if (b_r[0]) begin
      addend_s = a_r;
    end else begin
      addend_s = P_ZERO;
    end

    sum_s = acc_r + addend_s;
  end

  // Control FSM plus shift-and-add datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      have_mcand_r    <= 1'b0;
      have_mplier_r   <= 1'b0;
      mcand_r         <= OP_ZERO;
      mplier_r        <= OP_ZERO;
      acc_r           <= P_ZERO;
      a_r             <= P_ZERO;
      b_r             <= OP_ZERO;
      cnt_r           <= CNT_ZERO;
      output_tdata_r  <= P_ZERO;
      output_tvalid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mcand_fire_s) begin
            mcand_r      <= input_multiplicand_tdata;
            have_mcand_r <= 1'b1;
          end
          if (mplier_fire_s) begin
            mplier_r      <= input_multiplier_tdata;
            have_mplier_r <= 1'b1;
          end
          if (start_s) begin
            acc_r   <= P_ZERO;
            a_r     <= {OP_ZERO, mcand_next_s};
            b_r     <= mplier_next_s;
            cnt_r   <= CNT_ZERO;
            state_r <= ST_CALC;
          end
        end

        ST_CALC: begin
          acc_r <= sum_s;
          a_r   <= a_r << 1;
          b_r   <= b_r >> 1;
          cnt_r <= cnt_r + CNT_ONE;
          // The last partial product goes straight to the output register.
          if (cnt_r == CNT_LAST) begin
            output_tdata_r  <= sum_s;
            output_tvalid_r <= 1'b1;
            state_r         <= ST_OUT;
          end
        end

        ST_OUT: begin
          // Flags stay set until here so no operand is taken while busy.
          if (output_tready) begin
            output_tvalid_r <= 1'b0;
            have_mcand_r    <= 1'b0;
            have_mplier_r   <= 1'b0;
            state_r         <= ST_IDLE;
          end
        end

        default: begin
          state_r         <= ST_IDLE;
          have_mcand_r    <= 1'b0;
          have_mplier_r   <= 1'b0;
          output_tvalid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplication.sv
// Directed bench for multiplication: a table of operand pairs with hand-computed
// products, plus hand-written sequences for staggered operands, backpressure,
// reset during calculation and back-to-back throughput.
module tb_multiplication;

  localparam int SIZE = 64;
  localparam int LAT  = 64;

  logic              clk;
  logic              rst;
  logic [SIZE-1:0]   mcand_data;
  logic              mcand_valid;
  logic              mcand_ready;
  logic [SIZE-1:0]   mplier_data;
  logic              mplier_valid;
  logic              mplier_ready;
  logic [2*SIZE-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [SIZE-1:0]   a;
    logic [SIZE-1:0]   b;
    logic [2*SIZE-1:0] p;
  } vec_t;

  vec_t vecs [8];

  multiplication #(.SIZE(SIZE)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .input_multiplicand_tdata  (mcand_data),
    .input_multiplicand_tvalid (mcand_valid),
    .input_multiplicand_tready (mcand_ready),
    .input_multiplier_tdata    (mplier_data),
    .input_multiplier_tvalid   (mplier_valid),
    .input_multiplier_tready   (mplier_ready),
    .output_tdata              (out_data),
    .output_tvalid             (out_valid),
    .output_tready             (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [2*SIZE-1:0] act, input logic [2*SIZE-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for output_tvalid, counting edges; the bound keeps a dead DUT from hanging.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic run_pair(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                          input logic [2*SIZE-1:0] exp, input string nm);
    int n;
    mcand_data   = a;
    mplier_data  = b;
    mcand_valid  = 1'b1;
    mplier_valid = 1'b1;
    tick();
    mcand_valid  = 1'b0;
    mplier_valid = 1'b0;
    check({nm, " tready_drop"}, {mcand_ready, mplier_ready}, 2'b00);
    wait_valid(n);
    check({nm, " latency"}, n, LAT);
    check({nm, " product"}, out_data, exp);
    tick();
    check({nm, " valid_one_cycle"}, out_valid, 1'b0);
    check({nm, " tready_back"}, {mcand_ready, mplier_ready}, 2'b11);
  endtask

  initial begin
    int n;
    int j;
    int prev;
    int t [3];
    logic [SIZE-1:0]   ba [3];
    logic [SIZE-1:0]   bb [3];
    logic [2*SIZE-1:0] bp [3];

    vecs[0] = '{64'd69814, 64'd288, 128'd20106432};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    vecs[2] = '{64'd0, 64'd12345, 128'd0};
    vecs[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 128'hFFFF_FFFE_0000_0001};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 128'h1_FFFF_FFFF_FFFF_FFFE};
    vecs[5] = '{64'd1, 64'h8000_0000_0000_0000, 128'h8000_0000_0000_0000};
    vecs[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                128'h4000_0000_0000_0000_0000_0000_0000_0000};
    vecs[7] = '{64'd12345, 64'd0, 128'd0};

    rst          = 1'b0;
    mcand_data   = 64'd0;
    mcand_valid  = 1'b0;
    mplier_data  = 64'd0;
    mplier_valid = 1'b0;
    out_ready    = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_data", out_data, 128'd0);
    check("reset treadys", {mcand_ready, mplier_ready}, 2'b11);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Table-driven products, both operands offered together.
    for (int i = 0; i < 8; i++) begin
      run_pair(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // Staggered operands; a changed multiplicand is held on the bus while busy.
    mcand_data  = 64'h1_0000_0000;
    mcand_valid = 1'b1;
    tick();
    check("stagger mcand_ready_low", mcand_ready, 1'b0);
    check("stagger mplier_ready_high", mplier_ready, 1'b1);
    mcand_data = 64'd5;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("stagger no_recapture", mcand_ready, 1'b0);
    end
    mplier_data  = 64'h1_0000_0000;
    mplier_valid = 1'b1;
    tick();
    mcand_valid  = 1'b0;
    mplier_valid = 1'b0;
    check("stagger mplier_ready_low", mplier_ready, 1'b0);
    wait_valid(n);
    check("stagger latency", n, LAT);
    check("stagger product", out_data, 128'h1_0000_0000_0000_0000);
    tick();

    // Backpressure: result held for 10 cycles, then one handshake.
    out_ready    = 1'b0;
    mcand_data   = 64'd12345;
    mplier_data  = 64'd1000;
    mcand_valid  = 1'b1;
    mplier_valid = 1'b1;
    tick();
    mcand_valid  = 1'b0;
    mplier_valid = 1'b0;
    wait_valid(n);
    check("bp latency", n, LAT);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp valid_held", out_valid, 1'b1);
      check("bp data_held", out_data, 128'd12345000);
      check("bp treadys_low", {mcand_ready, mplier_ready}, 2'b00);
    end
    out_ready = 1'b1;
    tick();
    check("bp handshake_valid", out_valid, 1'b0);
    check("bp handshake_treadys", {mcand_ready, mplier_ready}, 2'b11);
    check("bp data_kept", out_data, 128'd12345000);
    tick();
    check("bp single_handshake", out_valid, 1'b0);

    // Reset asserted mid-calculation.
    mcand_data   = 64'd69814;
    mplier_data  = 64'd288;
    mcand_valid  = 1'b1;
    mplier_valid = 1'b1;
    tick();
    mcand_valid  = 1'b0;
    mplier_valid = 1'b0;
    for (int i = 0; i < 29; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("midreset out_valid", out_valid, 1'b0);
    check("midreset out_data", out_data, 128'd0);
    check("midreset treadys", {mcand_ready, mplier_ready}, 2'b11);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (out_valid) break;
    end
    check("midreset no_stale_result", out_valid, 1'b0);
    run_pair(64'd3, 64'd5, 128'd15, "after_reset");

    // Back-to-back pairs with tvalid held high continuously.
    ba[0] = 64'd7;          bb[0] = 64'd9;          bp[0] = 128'd63;
    ba[1] = 64'd1000000;    bb[1] = 64'd1000000;    bp[1] = 128'd1000000000000;
    ba[2] = 64'hFFFF_FFFF;  bb[2] = 64'd2;          bp[2] = 128'h1_FFFF_FFFE;
    mcand_data   = ba[0];
    mplier_data  = bb[0];
    mcand_valid  = 1'b1;
    mplier_valid = 1'b1;
    j    = 0;
    prev = 0;
    for (int c = 1; c <= 400 && j < 3; c++) begin
      tick();
      if (out_valid && prev == 0) begin
        t[j] = c;
        check($sformatf("b2b product%0d", j), out_data, bp[j]);
        j++;
        if (j < 3) begin
          mcand_data  = ba[j];
          mplier_data = bb[j];
        end else begin
          mcand_valid  = 1'b0;
          mplier_valid = 1'b0;
        end
      end
      prev = out_valid ? 1 : 0;
    end
    check("b2b count", j, 3);
    if (j == 3) begin
      check("b2b first_latency", t[0], LAT + 1);
      check("b2b gap01", t[1] - t[0], SIZE + 2);
      check("b2b gap12", t[2] - t[1], SIZE + 2);
    end
    tick();
    check("b2b idle_after", {out_valid, mcand_ready, mplier_ready}, 3'b011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
